// File: rtl/pwm_pkg.sv
// Shared PWM definitions: readback select encoding (common with the generator)
// and the capture FSM state encoding.
package pwm_pkg;

    typedef enum logic [1:0] {
        SEL_STATUS = 2'b00,
        SEL_CMP    = 2'b01,
        SEL_TOP    = 2'b10,
        SEL_CNT    = 2'b11
    } sel_t;

    typedef enum logic [1:0] {
        CAP_IDLE = 2'b00,
        CAP_HIGH = 2'b01,
        CAP_LOW  = 2'b10
    } cap_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchronizer for an asynchronous pin with single-cycle
// rise/fall pulses derived from the synchronized level.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~prev_q;
    assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures an incoming PWM waveform and reports high time / period in the
// generator's register encoding (cmp = high-1, top = period-1).
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int W           = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pwm_in,
    input  logic [1:0]   sel,
    output logic [W-1:0] q,
    output logic         valid,
    output logic         stuck,
    output logic         level
);

    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

    logic         rise, fall, stall;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] cmp_m_q, top_m_q, hi_shadow_q;
    logic [W-1:0] q_q, q_d;
    logic         valid_q, stuck_q, have_meas_q;
    cap_state_t   state_q;

    sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk     (clk),
        .rst     (rst),
        .async_i (pwm_in),
        .level_o (level),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    // Saturating counter restarted on every rise so cnt reads H-1 at fall, P-1 at rise.
    always_comb begin
        cnt_d = cnt_q;
        if (rise) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    assign stall = (cnt_q == CNT_MAX) && !rise && !fall;

    always_comb begin
        q_d = '0;
        case (sel_t'(sel))
            SEL_STATUS: q_d = {{(W-3){1'b0}}, level, stuck_q, have_meas_q};
            SEL_CMP:    q_d = cmp_m_q;
            SEL_TOP:    q_d = top_m_q;
            SEL_CNT:    q_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            cmp_m_q     <= '0;
            top_m_q     <= '0;
            hi_shadow_q <= '0;
            q_q         <= '0;
            valid_q     <= 1'b0;
            stuck_q     <= 1'b0;
            have_meas_q <= 1'b0;
            state_q     <= CAP_IDLE;
        end else begin
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            valid_q <= 1'b0;
            if (stall) begin
                // Period too long to represent: drop to IDLE, keep last measurement.
                state_q <= CAP_IDLE;
                stuck_q <= 1'b1;
            end else begin
                case (state_q)
                    CAP_IDLE: begin
                        if (rise) begin
                            state_q <= CAP_HIGH;
                            stuck_q <= 1'b0;
                        end
                    end
                    CAP_HIGH: begin
                        if (fall) begin
                            state_q     <= CAP_LOW;
                            hi_shadow_q <= cnt_q;
                        end
                    end
                    CAP_LOW: begin
                        if (rise) begin
                            state_q     <= CAP_HIGH;
                            cmp_m_q     <= hi_shadow_q;
                            top_m_q     <= cnt_q;
                            valid_q     <= 1'b1;
                            have_meas_q <= 1'b1;
                        end
                    end
                    default: state_q <= CAP_IDLE;
                endcase
            end
        end
    end

    assign q     = q_q;
    assign valid = valid_q;
    assign stuck = stuck_q;

endmodule
